// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: groups the sequencer's control handshake and shared-neuron bus.
//   start    : request to run the layer (env -> sequencer)
//   busy     : sequencer not idle
//   done     : one-cycle pulse at layer completion
//   n_idx    : selected neuron row (drives external weight/bias mux)
//   n_start  : one-cycle start pulse to the shared neuron
//   n_done   : done pulse from the shared neuron
//   n_result : saturated signed result from the shared neuron
//   outputs  : captured per-output results
//   max_idx  : index of the largest captured output
// Modports: master = sequencer side, slave = environment / neuron side.
interface layer_sequencer_if #(
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned IDXW        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
);
   logic                   start;
   logic                   busy;
   logic                   done;
   logic [IDXW-1:0]        n_idx;
   logic                   n_start;
   logic                   n_done;
   logic signed [15:0]     n_result;
   logic signed [15:0]     outputs [NUM_NEURONS];
   logic [IDXW-1:0]        max_idx;

   modport master (
      input  start, n_done, n_result,
      output busy, done, n_idx, n_start, outputs, max_idx
   );

   modport slave (
      output start, n_done, n_result,
      input  busy, done, n_idx, n_start, outputs, max_idx
   );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: time-multiplexes one shared neuron MAC across all outputs of a
// fully-connected layer. Walks neuron rows 0..NUM_NEURONS-1, pulses the neuron,
// waits for its done, captures the (optionally ReLU-clamped) result and tracks the
// running argmax.
// Ports:
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : layer_sequencer_if.master (start/busy/done, neuron handshake, results)
module layer_sequencer #(
   parameter int unsigned INPUT_SIZE  = 16,
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned RELU        = 1,
   parameter int unsigned IDXW        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input logic               clk,
   input logic               rstN,
   layer_sequencer_if.master bus
);

   typedef enum logic [2:0] {StIdle, StLaunch, StWait, StCapture, StFinish} state_e;

   localparam logic [IDXW-1:0] LastIdx = IDXW'(NUM_NEURONS - 1);

   // Elaboration-time sanity checks on the configuration.
   if (NUM_NEURONS < 1) begin : g_bad_num_neurons
      $error("layer_sequencer: NUM_NEURONS must be >= 1");
   end
   if (INPUT_SIZE < 1) begin : g_bad_input_size
      $error("layer_sequencer: INPUT_SIZE must be >= 1");
   end

   state_e             state_q, state_d;
   logic [IDXW-1:0]    n_idx_q, n_idx_d;
   logic [IDXW-1:0]    max_idx_q, max_idx_d;
   logic signed [15:0] max_val_q, max_val_d;
   logic signed [15:0] outputs_q [NUM_NEURONS];
   logic signed [15:0] outputs_d [NUM_NEURONS];
   logic signed [15:0] capt_val;

   // Value that would be stored if this were the CAPTURE cycle.
   assign capt_val = ((RELU != 0) && (bus.n_result < 0)) ? 16'sd0 : bus.n_result;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= StIdle;
         n_idx_q   <= '0;
         max_idx_q <= '0;
         max_val_q <= '0;
         outputs_q <= '{default: '0};
      end else begin
         state_q   <= state_d;
         n_idx_q   <= n_idx_d;
         max_idx_q <= max_idx_d;
         max_val_q <= max_val_d;
         outputs_q <= outputs_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      n_idx_d     = n_idx_q;
      max_idx_d   = max_idx_q;
      max_val_d   = max_val_q;
      outputs_d   = outputs_q;
      bus.n_start = 1'b0;
      bus.busy    = 1'b1;
      bus.done    = 1'b0;

      unique case (state_q)
         StIdle: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               state_d   = StLaunch;
               n_idx_d   = '0;
               max_idx_d = '0;
               max_val_d = '0;
            end
         end

         StLaunch: begin
            bus.n_start = 1'b1;
            state_d     = StWait;
         end

         // n_result is only valid the cycle after n_done, so capture happens next state.
         StWait: begin
            if (bus.n_done) begin
               state_d = StCapture;
            end
         end

         StCapture: begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
               if (n_idx_q == IDXW'(i)) begin
                  outputs_d[i] = capt_val;
               end
            end
            // Strict compare: ties keep the lower index.
            if ((n_idx_q == '0) || (capt_val > max_val_q)) begin
               max_val_d = capt_val;
               max_idx_d = n_idx_q;
            end
            if (n_idx_q == LastIdx) begin
               state_d = StFinish;
            end else begin
               n_idx_d = n_idx_q + 1'b1;
               state_d = StLaunch;
            end
         end

         StFinish: begin
            bus.done = 1'b1;
            n_idx_d  = '0;
            state_d  = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.n_idx   = n_idx_q;
   assign bus.max_idx = max_idx_q;
   assign bus.outputs = outputs_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: three sequencer instances (N=4 ReLU, N=4 no-ReLU, N=1 no-ReLU),
// each driven by a behavioural shared-neuron model.
module tb_layer_sequencer;
   localparam int INPUT_SIZE = 16;
   localparam int PER_N      = INPUT_SIZE + 4;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int mon_err  = 0;

   int nn_of[3]   = '{4, 4, 1};
   bit relu_of[3] = '{1'b1, 1'b0, 1'b0};

   logic               st[3];
   logic               ns[3];
   logic               nd[3];
   logic signed [15:0] nr[3];
   int                 nidx[3];
   int                 mx[3];
   logic               dn[3];
   logic               bz[3];
   logic signed [15:0] outv[3][4];

   int                 raw[3][4];
   logic signed [15:0] exp_o[4];
   int                 exp_mx;

   layer_sequencer_if #(.NUM_NEURONS(4), .IDXW(2)) if0 ();
   layer_sequencer_if #(.NUM_NEURONS(4), .IDXW(2)) if1 ();
   layer_sequencer_if #(.NUM_NEURONS(1), .IDXW(1)) if2 ();

   layer_sequencer #(.INPUT_SIZE(16), .NUM_NEURONS(4), .RELU(1), .IDXW(2)) dut0 (
      .clk(clk), .rstN(rstN), .bus(if0.master));
   layer_sequencer #(.INPUT_SIZE(16), .NUM_NEURONS(4), .RELU(0), .IDXW(2)) dut1 (
      .clk(clk), .rstN(rstN), .bus(if1.master));
   layer_sequencer #(.INPUT_SIZE(16), .NUM_NEURONS(1), .RELU(0), .IDXW(1)) dut2 (
      .clk(clk), .rstN(rstN), .bus(if2.master));

   assign if0.start = st[0];
   assign if1.start = st[1];
   assign if2.start = st[2];
   assign if0.n_done = nd[0];
   assign if1.n_done = nd[1];
   assign if2.n_done = nd[2];
   assign if0.n_result = nr[0];
   assign if1.n_result = nr[1];
   assign if2.n_result = nr[2];
   assign ns[0] = if0.n_start;
   assign ns[1] = if1.n_start;
   assign ns[2] = if2.n_start;
   assign nidx[0] = int'(if0.n_idx);
   assign nidx[1] = int'(if1.n_idx);
   assign nidx[2] = int'(if2.n_idx);
   assign mx[0] = int'(if0.max_idx);
   assign mx[1] = int'(if1.max_idx);
   assign mx[2] = int'(if2.max_idx);
   assign dn[0] = if0.done;
   assign dn[1] = if1.done;
   assign dn[2] = if2.done;
   assign bz[0] = if0.busy;
   assign bz[1] = if1.busy;
   assign bz[2] = if2.busy;

   for (genvar g = 0; g < 4; g++) begin : g_out
      assign outv[0][g] = if0.outputs[g];
      assign outv[1][g] = if1.outputs[g];
      assign outv[2][g] = (g == 0) ? if2.outputs[0] : 16'sd0;
   end

   function automatic logic signed [15:0] sat(input int x);
      if (x > 32767) return 16'sh7fff;
      if (x < -32768) return 16'sh8000;
      return 16'(x);
   endfunction

   // Nominal neuron: done at the (INPUT_SIZE+2)th edge after start, result updated on the
   // edge after done; before that the result bus carries junk.
   int                 cnt[3];
   logic               upd[3];
   logic signed [15:0] pend[3];
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int k = 0; k < 3; k++) begin
            cnt[k] <= 0;
            upd[k] <= 1'b0;
            nd[k]  <= 1'b0;
            nr[k]  <= 16'sd0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            nd[k] <= 1'b0;
            if (upd[k]) begin
               nr[k]  <= pend[k];
               upd[k] <= 1'b0;
            end
            if (cnt[k] != 0) begin
               cnt[k] <= cnt[k] - 1;
               if (cnt[k] == 1) begin
                  nd[k]  <= 1'b1;
                  upd[k] <= 1'b1;
               end
            end
            if (ns[k]) begin
               if (cnt[k] != 0 || nd[k]) begin
                  mon_err++;
                  $display("FAIL n_start_while_neuron_busy dut%0d: start at cycle %0d, required none",
                           k, cyc);
               end
               cnt[k]  <= INPUT_SIZE + 1;
               pend[k] <= (nidx[k] < 4) ? sat(raw[k][nidx[k]]) : 16'sd0;
               nr[k]   <= 16'($urandom);
            end
         end
      end
   end

   // Protocol monitor: n_start width/spacing/index order and n_idx stability.
   int   last_l[3]  = '{-1, -1, -1};
   int   exp_idx[3] = '{0, 0, 0};
   logic prev_ns[3] = '{1'b0, 1'b0, 1'b0};
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rstN || !bz[k]) begin
            last_l[k]  = -1;
            exp_idx[k] = 0;
         end
         if (rstN && ns[k]) begin
            if (prev_ns[k]) begin
               mon_err++;
               $display("FAIL n_start_width dut%0d: high for 2+ cycles, required 1", k);
            end
            if (last_l[k] >= 0 && cyc - last_l[k] != PER_N) begin
               mon_err++;
               $display("FAIL n_start_spacing dut%0d: got %0d, required %0d", k,
                        cyc - last_l[k], PER_N);
            end
            if (nidx[k] != exp_idx[k]) begin
               mon_err++;
               $display("FAIL launch_idx dut%0d: got %0d, required %0d", k, nidx[k], exp_idx[k]);
            end
            last_l[k] = cyc;
            exp_idx[k]++;
         end else if (rstN && last_l[k] >= 0 && cyc - last_l[k] < PER_N &&
                      nidx[k] != exp_idx[k] - 1) begin
            mon_err++;
            $display("FAIL n_idx_stable dut%0d: got %0d, required %0d", k, nidx[k],
                     exp_idx[k] - 1);
         end
         prev_ns[k] = rstN && ns[k];
      end
   end

   function automatic void check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endfunction

   // Reference: saturate, optional ReLU, argmax with lowest index winning ties.
   function automatic void model(input int k);
      logic signed [15:0] v;
      exp_mx = 0;
      for (int i = 0; i < nn_of[k]; i++) begin
         v = sat(raw[k][i]);
         if (relu_of[k] && v < 0) v = '0;
         exp_o[i] = v;
         if (v > exp_o[exp_mx]) exp_mx = i;
      end
   endfunction

   // Sum of INPUT_SIZE Q8.8 products of input 1.0 and weight (row+1)*16, plus bias.
   function automatic int real_sum(input int row, input int bias);
      int acc = 0;
      for (int i = 0; i < INPUT_SIZE; i++) acc += (256 * ((row + 1) * 16)) >>> 8;
      return acc + bias;
   endfunction

   // Call at a negedge; returns at the negedge of the cycle after done.
   task automatic run_layer(input int k, input string tag);
      int c0;
      int me0;
      int guard;
      int lat;
      me0 = mon_err;
      c0  = cyc;
      st[k] = 1'b1;
      @(negedge clk);
      st[k] = 1'b0;
      check({tag, " busy_rise"}, longint'(bz[k]), 1);
      check({tag, " n_start_first"}, longint'(ns[k]), 1);
      guard = 0;
      while (!dn[k] && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      lat = dn[k] ? cyc - c0 : -1;
      check({tag, " latency"}, lat, nn_of[k] * PER_N + 1);
      for (int i = 0; i < nn_of[k]; i++)
         check($sformatf("%s out[%0d]", tag, i), outv[k][i], exp_o[i]);
      check({tag, " max_idx"}, mx[k], exp_mx);
      @(negedge clk);
      check({tag, " done_one_cycle"}, longint'(dn[k]), 0);
      check({tag, " busy_fall"}, longint'(bz[k]), 0);
      check({tag, " protocol_errors"}, mon_err - me0, 0);
   endtask

   typedef struct {
      int               k;
      logic [3:0][31:0] r;
      logic [3:0][15:0] e;
      int               emx;
   } vec_t;
   vec_t vecs[$];

   task automatic add_vec(input int k, input int r0, input int r1, input int r2, input int r3,
                          input int e0, input int e1, input int e2, input int e3, input int emx);
      vec_t v;
      v.k = k;
      v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
      v.e[0] = 16'(e0); v.e[1] = 16'(e1); v.e[2] = 16'(e2); v.e[3] = 16'(e3);
      v.emx = emx;
      vecs.push_back(v);
   endtask

   task automatic load_vec(input int n);
      for (int j = 0; j < 4; j++) begin
         raw[vecs[n].k][j] = int'($signed(vecs[n].r[j]));
         exp_o[j]          = $signed(vecs[n].e[j]);
      end
      exp_mx = vecs[n].emx;
   endtask

   initial begin
      int dones;
      int extra;
      int guard;
      int k;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         for (int j = 0; j < 4; j++) raw[i][j] = 0;
      end

      add_vec(0, real_sum(0, 0), real_sum(1, 0), real_sum(2, 0), real_sum(3, 0),
              256, 512, 768, 1024, 3);
      add_vec(0, -100, 50, -3, 50, 0, 50, 0, 50, 1);
      add_vec(1, -100, 50, -3, 50, -100, 50, -3, 50, 1);
      add_vec(0, 40000, -40000, 1000, 39999, 32767, 0, 1000, 32767, 0);
      add_vec(1, -40000, -5, -40000, -6, -32768, -5, -32768, -6, 1);
      add_vec(0, -1, -2, -3, -4, 0, 0, 0, 0, 0);
      add_vec(2, -7, 0, 0, 0, -7, 0, 0, 0, 0);
      add_vec(2, 40000, 0, 0, 0, 32767, 0, 0, 0, 0);

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset busy dut%0d", i), longint'(bz[i]), 0);
         check($sformatf("reset done dut%0d", i), longint'(dn[i]), 0);
         check($sformatf("reset n_start dut%0d", i), longint'(ns[i]), 0);
         check($sformatf("reset n_idx dut%0d", i), nidx[i], 0);
         check($sformatf("reset max_idx dut%0d", i), mx[i], 0);
      end
      for (int j = 0; j < 4; j++) check($sformatf("reset out[%0d]", j), outv[0][j], 0);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven layer runs
      for (int n = 0; n < vecs.size(); n++) begin
         load_vec(n);
         run_layer(vecs[n].k, $sformatf("vec%0d", n));
      end

      // Back-to-back: start in the cycle after done, identical results
      load_vec(0);
      run_layer(0, "b2b_first");
      run_layer(0, "b2b_second");

      // start held high throughout a run: exactly one run and one done pulse
      dones = 0;
      extra = 0;
      st[0] = 1'b1;
      @(negedge clk);
      guard = 0;
      while (bz[0] && guard < 2000) begin
         if (dn[0]) dones++;
         @(negedge clk);
         guard++;
      end
      st[0] = 1'b0;
      check("spam guard", longint'(guard < 2000), 1);
      check("spam done_count", dones, 1);
      repeat (30) begin
         @(negedge clk);
         if (bz[0] || dn[0]) extra++;
      end
      check("spam no_second_run", extra, 0);

      // Reset in the middle of the third neuron's WAIT
      load_vec(1);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      guard = 0;
      dones = 0;
      while (!(ns[0] && nidx[0] == 2) && guard < 200) begin
         if (dn[0]) dones++;
         @(negedge clk);
         guard++;
      end
      check("midreset reached_third", nidx[0], 2);
      repeat (5) @(negedge clk);
      rstN = 1'b0;
      #1;
      for (int j = 0; j < 4; j++) check($sformatf("midreset out[%0d]", j), outv[0][j], 0);
      check("midreset busy", longint'(bz[0]), 0);
      check("midreset done", longint'(dn[0]), 0);
      check("midreset n_idx", nidx[0], 0);
      check("midreset no_done_pulse", dones, 0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      load_vec(0);
      run_layer(0, "after_reset");

      // Randomized runs against the reference model
      for (int n = 0; n < 12; n++) begin
         k = int'($urandom_range(2));
         for (int j = 0; j < 4; j++) begin
            if ($urandom_range(1) == 1) raw[k][j] = int'($urandom_range(100000)) - 50000;
            else raw[k][j] = int'($urandom_range(6)) - 3;
         end
         model(k);
         run_layer(k, $sformatf("rand%0d_dut%0d", n, k));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global safety net against a hung run.
   initial begin
      #2000000;
      $display("FAIL global_timeout: reached time limit, required $finish earlier");
      $fatal(1, "timeout");
   end

endmodule
